// File: rtl/car_sensor_emitter.sv
// car_sensor_emitter: emits the two-sensor pattern a car produces while
// passing an outer/inner sensor pair. Each request runs PH1, PH2, PH3 and
// GAP for dwell+1 cycles each, then returns to IDLE with a one-cycle done
// pulse and an occupancy count update (+1 entry, -1 exit).
// Optional build macro: EMITTER_CNT_SAT_EN makes the occupancy count
// saturate at 0 and 7 instead of wrapping modulo 8.
module car_sensor_emitter #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic [1:0]         dout,
  output logic               busy,
  output logic               done,
  output logic [2:0]         cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [DWELL_W-1:0] TIMER_ONE = DWELL_W'(1);

  state_t             state;
  logic [DWELL_W-1:0] timer;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_q;

  // Pattern shown while in a given state; exit reverses the sensor order.
  function automatic logic [1:0] pattern(input state_t s, input logic d);
    logic [1:0] p;
    p = 2'b00;
    case (s)
      PH1:     p = d ? 2'b01 : 2'b10;
      PH2:     p = 2'b11;
      PH3:     p = d ? 2'b10 : 2'b01;
      default: p = 2'b00;
    endcase
    return p;
  endfunction

  // Occupancy update applied when a sequence completes.
  function automatic logic [2:0] next_cnt(input logic [2:0] c, input logic d);
    logic [2:0] n;
`ifdef EMITTER_CNT_SAT_EN
    if (!d) n = (c == 3'd7) ? c : c + 3'd1;
    else    n = (c == 3'd0) ? c : c - 3'd1;
`else
    n = d ? c - 3'd1 : c + 3'd1;
`endif
    return n;
  endfunction

  // Sequencer: state, dwell timer, latched request and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      dwell_q <= '0;
      dir_q   <= 1'b0;
      dout    <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Abort together with start keeps the emitter idle.
          if (start && !abort) begin
            state   <= PH1;
            dir_q   <= dir;
            dwell_q <= dwell;
            timer   <= dwell;
            dout    <= pattern(PH1, dir);
            busy    <= 1'b1;
          end
        end
        PH1, PH2, PH3, GAP: begin
          if (abort) begin
            state <= IDLE;
            timer <= '0;
            dout  <= 2'b00;
            busy  <= 1'b0;
          end else if (timer != '0) begin
            timer <= timer - TIMER_ONE;
          end else begin
            timer <= dwell_q;
            case (state)
              PH1: begin
                state <= PH2;
                dout  <= pattern(PH2, dir_q);
              end
              PH2: begin
                state <= PH3;
                dout  <= pattern(PH3, dir_q);
              end
              PH3: begin
                state <= GAP;
                dout  <= pattern(GAP, dir_q);
              end
              default: begin
                state <= IDLE;
                timer <= '0;
                dout  <= 2'b00;
                busy  <= 1'b0;
                done  <= 1'b1;
                cnt   <= next_cnt(cnt, dir_q);
              end
            endcase
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          dout  <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/car_sensor_emitter.md
CAR_SENSOR_EMITTER -- requirements
Module: car_sensor_emitter

Interface
REQ-001 Parameter DWELL_W, 4, width of the per-phase dwell count input.
REQ-002 Clk  input  1  sole clock; all state updates SHALL occur on its rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Start  input  1  single-cycle request to emit one car-passage sequence.
REQ-005 Dir  input  1  direction sampled with Start: 0 = entry, 1 = exit.
REQ-006 Dwell  input  DWELL_W  sampled with Start; each phase SHALL last Dwell+1 cycles.
REQ-007 Abort  input  1  cancels a sequence in progress.
REQ-008 Dout  output  2  emitted two-sensor pattern, bit 1 = outer sensor, bit 0 = inner sensor.
REQ-009 Busy  output  1  high while a sequence is in progress.
REQ-010 Done  output  1  one-cycle pulse on sequence completion.
REQ-011 Cnt  output  3  occupancy count of completed entries minus completed exits.

Function
REQ-012 The FSM SHALL have the states IDLE, PH1, PH2, PH3 and GAP, all registered; Dout, Busy, Done and Cnt SHALL be register outputs.
REQ-013 Pattern by state: IDLE and GAP = 00; PH1/PH2/PH3 = 10/11/01 when Dir=0; PH1/PH2/PH3 = 01/11/10 when Dir=1.
REQ-014 Start SHALL be accepted only in IDLE; on acceptance Dir and Dwell are latched and the FSM enters PH1 at the next edge.
REQ-015 Start while Busy=1 SHALL be ignored, with no queuing and no effect on the latched Dir or Dwell.
REQ-016 Transitions: PH1->PH2->PH3->GAP->IDLE, each taken after the state has been held Dwell+1 cycles, using an internal DWELL_W-bit down-counter.
REQ-017 Latency: with Start accepted in cycle T, Dout SHALL show the first pattern at T+1 and IDLE SHALL be re-entered at T+1+4*(Dwell+1).
REQ-018 Busy SHALL be 1 exactly in PH1, PH2, PH3 and GAP.
REQ-019 Done SHALL be 1 for the single cycle in which IDLE is re-entered from GAP.
REQ-020 Cnt SHALL change in that same cycle: +1 for entry, -1 for exit.
REQ-021 Back-to-back operation: Start asserted in the Done cycle SHALL be accepted, giving PH1 in the following cycle.
REQ-022 Abort in any non-IDLE state SHALL force IDLE at the next edge with Dout=00, without asserting Done and without changing Cnt.
REQ-023 Abort SHALL take priority over phase advance.
REQ-024 Abort in IDLE SHALL be ignored, and Abort together with Start in IDLE SHALL leave the FSM in IDLE.
REQ-025 Dwell=0 SHALL give one-cycle phases with no special casing.
REQ-026 Dwell changes while Busy SHALL have no effect.
REQ-027 Default Cnt arithmetic SHALL be modulo 8: 7+1=0 and 0-1=7.

Reset
REQ-028 Rst_n=0 SHALL immediately, without a clock edge, set state=IDLE, Dout=00, Busy=0, Done=0, Cnt=0, and clear the dwell counter and the latched Dir.
REQ-029 Reset mid-sequence SHALL abandon the sequence with no Done pulse.
REQ-030 The first Start SHALL be honoured on the first rising edge after Rst_n deasserts.

Configuration
REQ-031 With macro EMITTER_CNT_SAT_EN defined, Cnt SHALL saturate: an entry at 7 holds 7 and an exit at 0 holds 0, while Done still pulses.
REQ-032 Without EMITTER_CNT_SAT_EN, Cnt SHALL wrap per REQ-027.
REQ-033 The macro SHALL not affect timing, Dout, Busy or Done.

Verification
REQ-034 Reset, then Start=1, Dir=0, Dwell=0 at cycle T -> Dout 10,11,01,00 at T+1..T+4; Done=1 and Cnt=1 at T+5; Busy=1 for T+1..T+4.
REQ-035 Start, Dir=1, Dwell=2 with Cnt=1 -> Dout 01 x3, 11 x3, 10 x3, 00 x3; Done at T+13; Cnt=0.
REQ-036 Start re-asserted during PH2 with a different Dir -> ignored, sequence unchanged; a second Start in the Done cycle -> PH1 the next cycle.
REQ-037 Abort during PH3 with Dwell=3 -> Dout=00 and state IDLE next cycle, Done never asserts, Cnt unchanged.
REQ-038 Eight entries from Cnt=0 -> Cnt=0 without EMITTER_CNT_SAT_EN and Cnt=7 with it; an exit at Cnt=0 -> 7 without the macro and 0 with it.
REQ-039 Rst_n pulsed low asynchronously mid-PH2 -> all outputs reset before the next edge, no Done, and Start accepted after release.
